// File: rtl/l2_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single shared L2 port.
// Tie policy: fixed D-priority by default; round robin when ARB_ROUND_ROBIN_EN is defined.
module l2_arbiter #(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   state_e              r_state;
   logic                r_l2_read;
   logic                r_l2_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic                w_i_req;
   logic                w_d_req;
   logic                w_grant_d;

   assign w_i_req = i_read;
   assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d;

   // On a tie, favour whichever requester was not granted last.
   assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_d <= 1'b0;
      end else if (r_state == StIdle && (w_i_req || w_d_req)) begin
         r_last_d <= w_grant_d;
      end
   end
`else
   assign w_grant_d = w_d_req;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_l2_read  <= 1'b0;
         r_l2_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant_d) begin
                  r_state    <= StBusyD;
                  r_addr     <= d_addr;
                  r_wdata    <= d_wdata;
                  // A simultaneous read and write from the D-cache is a write-back.
                  r_l2_write <= d_write;
                  r_l2_read  <= ~d_write;
               end else if (w_i_req) begin
                  r_state    <= StBusyI;
                  r_addr     <= i_addr;
                  r_wdata    <= '0;
                  r_l2_write <= 1'b0;
                  r_l2_read  <= 1'b1;
               end
            end
            StBusyI, StBusyD: begin
               if (l2_resp) begin
                  r_state    <= StIdle;
                  r_l2_read  <= 1'b0;
                  r_l2_write <= 1'b0;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_l2_read  <= 1'b0;
               r_l2_write <= 1'b0;
            end
         endcase
      end
   end

   assign l2_read  = r_l2_read;
   assign l2_write = r_l2_write;
   assign l2_addr  = r_addr;
   assign l2_wdata = r_wdata;

   assign i_resp  = (r_state == StBusyI) & l2_resp;
   assign d_resp  = (r_state == StBusyD) & l2_resp;
   assign i_rdata = i_resp ? l2_rdata : '0;
   assign d_rdata = d_resp ? l2_rdata : '0;

endmodule
